fme_sad_accum: RTL

//  Sum-of-absolute-differences accumulator and best-candidate selector for FME.

---
 rtl/fme_pkg.sv | 22 ++
 rtl/fme_absdiff_row.sv | 55 +++++
 rtl/fme_sad_accum.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fme_pkg.sv
// Shared definitions for the FME SAD accumulator: default pixel width,
// a constant-evaluable clog2 helper and the search FSM state type.
package fme_pkg;

  localparam int FME_DATAWIDTH = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } fme_state_e;

endpackage

// File: rtl/fme_absdiff_row.sv
// Pipeline stage 1: per-pixel |cand - cur| for one row beat, summed by an
// adder tree and registered together with the beat's valid flag.
module fme_absdiff_row
  import fme_pkg::*;
#(
  parameter int DATAWIDTH = FME_DATAWIDTH,
  parameter int ROW_PIX   = 4,
  parameter int SUMWIDTH  = DATAWIDTH + clog2(ROW_PIX)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         valid_i,
  input  logic [ROW_PIX*DATAWIDTH-1:0] cand_i,
  input  logic [ROW_PIX*DATAWIDTH-1:0] cur_i,
  output logic                         valid_o,
  output logic [SUMWIDTH-1:0]          row_sum_o
);

  logic [DATAWIDTH-1:0] cand_px;
  logic [DATAWIDTH-1:0] cur_px;
  logic [SUMWIDTH-1:0]  row_sum_d;
  logic [SUMWIDTH-1:0]  row_sum_q;
  logic                 valid_q;

  // NOTE: every variable written in always_comb gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    row_sum_d = '0;
    cand_px   = '0;
    cur_px    = '0;
    for (int p = 0; p < ROW_PIX; p++) begin
      cand_px   = cand_i[p*DATAWIDTH +: DATAWIDTH];
      cur_px    = cur_i[p*DATAWIDTH +: DATAWIDTH];
      row_sum_d = row_sum_d + SUMWIDTH'((cand_px > cur_px) ? (cand_px - cur_px)
                                                           : (cur_px - cand_px));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= 1'b0;
      row_sum_q <= '0;
    end else if (enable) begin
      valid_q   <= valid_i;
      row_sum_q <= row_sum_d;
    end
  end

  assign valid_o   = valid_q;
  assign row_sum_o = row_sum_q;

endmodule

// File: rtl/fme_sad_accum.sv
// SAD accumulator and best-candidate selector for fractional motion estimation.
// Optional macro FME_SAD_CAND_OUT_EN exposes every completed candidate's SAD.
module fme_sad_accum
  import fme_pkg::*;
#(
  parameter int DATAWIDTH = FME_DATAWIDTH,
  parameter int ROW_PIX   = 4,
  parameter int BLK_ROWS  = 4,
  parameter int NUM_CAND  = 9,
  parameter int SADWIDTH  = DATAWIDTH + clog2(ROW_PIX * BLK_ROWS),
  parameter int IDXWIDTH  = clog2(NUM_CAND)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [ROW_PIX*DATAWIDTH-1:0] cand_pix,
  input  logic [ROW_PIX*DATAWIDTH-1:0] cur_pix,
  output logic                         busy,
  output logic                         done,
  output logic [SADWIDTH-1:0]          best_sad,
  output logic [IDXWIDTH-1:0]          best_idx
`ifdef FME_SAD_CAND_OUT_EN
  ,
  output logic [SADWIDTH-1:0]          cand_sad,
  output logic [IDXWIDTH-1:0]          cand_sad_idx,
  output logic                         cand_sad_valid
`endif
);

  localparam int SUMWIDTH = DATAWIDTH + clog2(ROW_PIX);
  localparam int ROWCW    = (BLK_ROWS > 1) ? clog2(BLK_ROWS) : 1;

  fme_state_e state_q, state_d;

  logic [ROWCW-1:0]    row_cnt_q;
  logic [IDXWIDTH-1:0] cand_cnt_q;
  logic                drain_cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [SADWIDTH-1:0] best_sad_q;
  logic [IDXWIDTH-1:0] best_idx_q;

  logic                s1_valid;
  logic [SUMWIDTH-1:0] s1_row_sum;
  logic                s1_last_q;
  logic [IDXWIDTH-1:0] s1_cand_q;

  logic [SADWIDTH-1:0] acc_q;
  logic [SADWIDTH-1:0] run_best_q;
  logic [IDXWIDTH-1:0] run_idx_q;
  logic [SADWIDTH-1:0] cand_total;

  logic beat, last_row, last_cand, accept_start, drain_end;

  assign beat         = in_valid && (state_q == ACCUM);
  assign last_row     = (row_cnt_q == ROWCW'(BLK_ROWS - 1));
  assign last_cand    = (cand_cnt_q == IDXWIDTH'(NUM_CAND - 1));
  assign accept_start = start && (state_q == IDLE);
  assign drain_end    = (state_q == DRAIN) && drain_cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (beat && last_row && last_cand) state_d = DRAIN;
      DRAIN:   if (drain_cnt_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset is synchronous and enable freezes everything, done included.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      cand_cnt_q  <= '0;
      drain_cnt_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      best_sad_q  <= '1;
      best_idx_q  <= '0;
    end else if (enable) begin
      state_q     <= state_d;
      drain_cnt_q <= (state_q == DRAIN) && !drain_cnt_q;
      done_q      <= drain_end;
      if (accept_start) begin
        busy_q     <= 1'b1;
        row_cnt_q  <= '0;
        cand_cnt_q <= '0;
      end else if (beat) begin
        if (last_row) begin
          row_cnt_q  <= '0;
          cand_cnt_q <= cand_cnt_q + IDXWIDTH'(1);
        end else begin
          row_cnt_q <= row_cnt_q + ROWCW'(1);
        end
      end
      if (drain_end) begin
        busy_q     <= 1'b0;
        best_sad_q <= run_best_q;
        best_idx_q <= run_idx_q;
      end
    end
  end

  fme_absdiff_row #(
    .DATAWIDTH (DATAWIDTH),
    .ROW_PIX   (ROW_PIX),
    .SUMWIDTH  (SUMWIDTH)
  ) u_absdiff (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .valid_i   (beat),
    .cand_i    (cand_pix),
    .cur_i     (cur_pix),
    .valid_o   (s1_valid),
    .row_sum_o (s1_row_sum)
  );

  assign cand_total = acc_q + SADWIDTH'(s1_row_sum);

  // Stage 2: strict less-than keeps the earlier (lower) index on a tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_last_q  <= 1'b0;
      s1_cand_q  <= '0;
      acc_q      <= '0;
      run_best_q <= '1;
      run_idx_q  <= '0;
    end else if (enable) begin
      s1_last_q <= last_row;
      s1_cand_q <= cand_cnt_q;
      if (accept_start) begin
        acc_q      <= '0;
        run_best_q <= '1;
        run_idx_q  <= '0;
      end else if (s1_valid) begin
        if (s1_last_q) begin
          acc_q <= '0;
          if (cand_total < run_best_q) begin
            run_best_q <= cand_total;
            run_idx_q  <= s1_cand_q;
          end
        end else begin
          acc_q <= cand_total;
        end
      end
    end
  end

`ifdef FME_SAD_CAND_OUT_EN
  logic [SADWIDTH-1:0] cand_sad_q;
  logic [IDXWIDTH-1:0] cand_sad_idx_q;
  logic                cand_sad_valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cand_sad_q       <= '0;
      cand_sad_idx_q   <= '0;
      cand_sad_valid_q <= 1'b0;
    end else if (enable) begin
      cand_sad_valid_q <= s1_valid && s1_last_q;
      if (s1_valid && s1_last_q) begin
        cand_sad_q     <= cand_total;
        cand_sad_idx_q <= s1_cand_q;
      end
    end
  end

  assign cand_sad       = cand_sad_q;
  assign cand_sad_idx   = cand_sad_idx_q;
  assign cand_sad_valid = cand_sad_valid_q;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

endmodule
